// File: rtl/fft_ctrl_pkg.sv
// rtl/fft_ctrl_pkg.sv - shared types for the SDF FFT stage sequencer
package fft_ctrl_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_STREAM, ST_DRAIN} ctrl_state_e;

   localparam int FRAME_CNT_W = 16;

   typedef struct packed {
      logic rot_valid;
      logic rot_en;
      logic sof;
   } rot_ctrl_t;

endpackage

// File: rtl/ctrl_align_pipe.sv
// rtl/ctrl_align_pipe.sv - delays rotator qualifiers to line up with twiddle ROM data
module ctrl_align_pipe
   import fft_ctrl_pkg::*;
#(
   parameter int DEPTH = 1
) (
   input  logic      i_clk,
   input  logic      i_rst_n,
   input  rot_ctrl_t i_ctrl,
   output rot_ctrl_t o_ctrl
);

   rot_ctrl_t stage_q [DEPTH];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
      end else begin
         stage_q[0] <= i_ctrl;
         for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
   end

   assign o_ctrl = stage_q[DEPTH-1];

endmodule

// File: rtl/fft_stage_ctrl.sv
// rtl/fft_stage_ctrl.sv - radix-2 DIF SDF stage sequencer; FFT_STAGE_CTRL_FRAME_CNT_EN adds o_frame_cnt
module fft_stage_ctrl
   import fft_ctrl_pkg::*;
#(
   parameter int LOG2_N  = 5,
   parameter int ROM_LAT = 1
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_valid,
   input  logic              i_sof,
   input  logic              i_last,
   output logic              o_dl_en,
   output logic              o_bf_en,
   output logic              o_out_valid,
   output logic [LOG2_N-2:0] o_rom_addr,
   output logic              o_rot_valid,
   output logic              o_rot_en,
   output logic              o_sof_out,
   output logic              o_busy,
   output logic              o_err_resync
`ifdef FFT_STAGE_CTRL_FRAME_CNT_EN
   ,
   output logic [FRAME_CNT_W-1:0] o_frame_cnt
`endif
);

   localparam logic [LOG2_N-1:0] CNT_LAST = '1;
   localparam logic [LOG2_N-1:0] HALF_M1  = {1'b0, {(LOG2_N-1){1'b1}}};

   ctrl_state_e       state_q, state_d;
   logic [LOG2_N-1:0] cnt_q, cnt_d;
   logic              last_q, last_d;
   logic              pend_q, pend_d;
   logic              err_q, err_d;
   logic              dl_en_q, dl_en_d;
   logic              bf_en_q, bf_en_d;
   logic [LOG2_N-2:0] addr_q, addr_d;
   rot_ctrl_t         ctl_q, ctl_d, ctl_rom;

   logic              half;
   logic [LOG2_N-2:0] j;
   logic              sof_beat;

   assign half     = cnt_q[LOG2_N-1];
   assign j        = cnt_q[LOG2_N-2:0];
   assign sof_beat = i_valid & i_sof;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      pend_d  = pend_q;
      err_d   = err_q;
      dl_en_d = 1'b0;
      bf_en_d = 1'b0;
      addr_d  = addr_q;
      ctl_d   = '0;
      case (state_q)
         ST_IDLE: begin
            if (sof_beat) begin
               state_d = ST_FILL;
               cnt_d   = LOG2_N'(1);
               last_d  = i_last;
               dl_en_d = 1'b1;
            end
         end
         ST_FILL, ST_STREAM: begin
            // A start mid-frame abandons whatever the delay line holds.
            if (sof_beat && cnt_q != '0) begin
               err_d   = 1'b1;
               state_d = ST_FILL;
               cnt_d   = LOG2_N'(1);
               last_d  = i_last;
               dl_en_d = 1'b1;
            end else if (i_valid) begin
               dl_en_d = 1'b1;
               cnt_d   = cnt_q + 1'b1;
               if (i_sof) last_d = i_last;
               if (half) begin
                  bf_en_d         = 1'b1;
                  addr_d          = '0;
                  ctl_d.rot_valid = 1'b1;
                  ctl_d.sof       = (j == '0);
               end else if (state_q == ST_STREAM) begin
                  addr_d          = j;
                  ctl_d.rot_valid = 1'b1;
                  ctl_d.rot_en    = 1'b1;
               end
               if (state_q == ST_FILL && cnt_q == HALF_M1) state_d = ST_STREAM;
               if (state_q == ST_STREAM && cnt_q == CNT_LAST && last_q) state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            dl_en_d         = 1'b1;
            addr_d          = j;
            ctl_d.rot_valid = 1'b1;
            ctl_d.rot_en    = 1'b1;
            cnt_d           = cnt_q + 1'b1;
            if (sof_beat) begin
               pend_d = 1'b1;
               last_d = i_last;
            end
            if (cnt_q == HALF_M1) begin
               pend_d = 1'b0;
               if (pend_q || sof_beat) begin
                  state_d = ST_FILL;
                  cnt_d   = LOG2_N'(1);
               end else begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         last_q  <= 1'b0;
         pend_q  <= 1'b0;
         err_q   <= 1'b0;
         dl_en_q <= 1'b0;
         bf_en_q <= 1'b0;
         addr_q  <= '0;
         ctl_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         pend_q  <= pend_d;
         err_q   <= err_d;
         dl_en_q <= dl_en_d;
         bf_en_q <= bf_en_d;
         addr_q  <= addr_d;
         ctl_q   <= ctl_d;
      end
   end

   ctrl_align_pipe #(.DEPTH(ROM_LAT)) u_align (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_ctrl  (ctl_q),
      .o_ctrl  (ctl_rom)
   );

`ifdef FFT_STAGE_CTRL_FRAME_CNT_EN
   logic [ROM_LAT-1:0]     fin_q;
   logic [FRAME_CNT_W-1:0] frame_cnt_q;

   // Frame is complete once its last rotated diff (j = N/2-1) leaves the rotator port.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         fin_q       <= '0;
         frame_cnt_q <= '0;
      end else begin
         fin_q[0] <= ctl_q.rot_valid & ctl_q.rot_en & (addr_q == '1);
         for (int i = 1; i < ROM_LAT; i++) fin_q[i] <= fin_q[i-1];
         if (fin_q[ROM_LAT-1]) frame_cnt_q <= frame_cnt_q + 1'b1;
      end
   end

   assign o_frame_cnt = frame_cnt_q;
`endif

   assign o_dl_en      = dl_en_q;
   assign o_bf_en      = bf_en_q;
   assign o_out_valid  = ctl_q.rot_valid;
   assign o_rom_addr   = addr_q;
   assign o_rot_valid  = ctl_rom.rot_valid;
   assign o_rot_en     = ctl_rom.rot_en;
   assign o_sof_out    = ctl_rom.sof;
   assign o_busy       = (state_q != ST_IDLE);
   assign o_err_resync = err_q;

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// tb/tb_fft_stage_ctrl.sv - directed bench for fft_stage_ctrl (N=32, ROM_LAT=1)
module tb_fft_stage_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       i_valid = 1'b0, i_sof = 1'b0, i_last = 1'b0;
   logic       o_dl_en, o_bf_en, o_out_valid, o_rot_valid, o_rot_en, o_sof_out, o_busy, o_err_resync;
   logic [3:0] o_rom_addr;
`ifdef FFT_STAGE_CTRL_FRAME_CNT_EN
   logic [15:0] o_frame_cnt;
`endif

   int         tests = 0, fails = 0, sof_cnt = 0;
   logic       p_ov = 1'b0, p_re = 1'b0, p_sf = 1'b0;
   logic [3:0] e_addr = 4'd0;

   always #5 clk = ~clk;

   fft_stage_ctrl #(.LOG2_N(5), .ROM_LAT(1)) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_valid      (i_valid),
      .i_sof        (i_sof),
      .i_last       (i_last),
      .o_dl_en      (o_dl_en),
      .o_bf_en      (o_bf_en),
      .o_out_valid  (o_out_valid),
      .o_rom_addr   (o_rom_addr),
      .o_rot_valid  (o_rot_valid),
      .o_rot_en     (o_rot_en),
      .o_sof_out    (o_sof_out),
      .o_busy       (o_busy),
      .o_err_resync (o_err_resync)
`ifdef FFT_STAGE_CTRL_FRAME_CNT_EN
      ,
      .o_frame_cnt  (o_frame_cnt)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, ".dl_en"}, o_dl_en, 0);
      chk({tag, ".bf_en"}, o_bf_en, 0);
      chk({tag, ".out_valid"}, o_out_valid, 0);
      chk({tag, ".rom_addr"}, o_rom_addr, 0);
      chk({tag, ".rot_valid"}, o_rot_valid, 0);
      chk({tag, ".rot_en"}, o_rot_en, 0);
      chk({tag, ".sof_out"}, o_sof_out, 0);
      chk({tag, ".busy"}, o_busy, 0);
      chk({tag, ".err"}, o_err_resync, 0);
   endtask

   task automatic clr_model();
      p_ov = 1'b0; p_re = 1'b0; p_sf = 1'b0;
      e_addr = 4'd0; sof_cnt = 0;
   endtask

   task automatic do_reset();
      i_valid = 1'b0; i_sof = 1'b0; i_last = 1'b0;
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk_quiet("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      clr_model();
   endtask

   // One clock: apply inputs, then check stage outputs for this beat and
   // rotator outputs for the previous beat.
   task automatic step(input logic iv, input logic is, input logic il, input logic edl,
                       input logic eov, input logic ebf, input logic [3:0] ej, input logic esf);
      i_valid = iv; i_sof = is; i_last = il;
      @(posedge clk); #1;
      if (eov) e_addr = ebf ? 4'd0 : ej;
      chk("dl_en", o_dl_en, edl);
      chk("out_valid", o_out_valid, eov);
      chk("rom_addr", o_rom_addr, e_addr);
      if (eov) chk("bf_en", o_bf_en, ebf);
      chk("rot_valid", o_rot_valid, p_ov);
      if (p_ov) begin
         chk("rot_en", o_rot_en, p_re);
         chk("sof_out", o_sof_out, p_sf);
      end
      sof_cnt += int'(o_sof_out);
      p_ov = eov; p_re = eov & ~ebf; p_sf = esf;
   endtask

   task automatic frame(input logic fill, input logic il);
      for (int k = 0; k < 32; k++)
         step(1'b1, k == 0, il, 1'b1, fill ? (k >= 16) : 1'b1, k >= 16, 4'(k), k == 16);
   endtask

   task automatic drain();
      for (int d = 0; d < 16; d++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'(d), 1'b0);
   endtask

   task automatic idle_step();
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
   endtask

   initial begin
      // single frame with i_last, then drain
      do_reset();
      frame(1'b1, 1'b1);
      drain();
      chk("t1.busy_after_drain", o_busy, 0);
      idle_step();
      chk("t1.sof_count", sof_cnt, 1);

      // three back-to-back frames, last one flagged
      do_reset();
      frame(1'b1, 1'b0);
      frame(1'b0, 1'b0);
      chk("t2.busy_streaming", o_busy, 1);
      frame(1'b0, 1'b1);
      drain();
      idle_step();
      idle_step();
      chk("t2.sof_count", sof_cnt, 3);
`ifdef FFT_STAGE_CTRL_FRAME_CNT_EN
      chk("t6.frame_cnt", o_frame_cnt, 3);
`endif

      // gapped input 1010..
      do_reset();
      for (int k = 0; k < 32; k++) begin
         step(1'b1, k == 0, 1'b1, 1'b1, k >= 16, k >= 16, 4'(k), k == 16);
         if (k < 31) idle_step();
      end
      drain();
      idle_step();
      chk("t3.busy_end", o_busy, 0);
      chk("t3.sof_count", sof_cnt, 1);

      // resync: sof at beat 7 of streaming half 0
      do_reset();
      frame(1'b1, 1'b0);
      for (int k = 0; k < 7; k++) step(1'b1, k == 0, 1'b0, 1'b1, 1'b1, 1'b0, 4'(k), 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
      chk("t4.err_set", o_err_resync, 1);
      for (int k = 0; k < 15; k++) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
      chk("t4.err_sticky", o_err_resync, 1);
      chk("t4.busy", o_busy, 1);
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 1'b1);
      do_reset();
      chk("t4.err_cleared", o_err_resync, 0);

      // asynchronous reset at beat 20
      do_reset();
      for (int k = 0; k < 20; k++)
         step(1'b1, k == 0, 1'b1, 1'b1, k >= 16, k >= 16, 4'(k), k == 16);
      rst_n = 1'b0;
      #1;
      chk_quiet("async_rst");
      @(posedge clk); #1;
      i_valid = 1'b0; i_sof = 1'b0;
      rst_n = 1'b1;
      clr_model();
      frame(1'b1, 1'b1);
      drain();
      idle_step();
      chk("t5.busy_end", o_busy, 0);
      chk("t5.sof_count", sof_cnt, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
